// File: rtl/usb_tb_sequencer.sv
// Simulation sequencer for usbModel benches: staggered node resets, cycle count,
// full-speed frame ticks, completion tracking and timeout. Optional USB_TB_SEQ_SIM_EN adds console reporting.
module usb_tb_sequencer #(
  parameter int NUM_NODES      = 2,
  parameter int CLK_FREQ_MHZ   = 12,
  parameter int RESET_CYCLES   = 10,
  parameter int STAGGER_CYCLES = 0,
  parameter int FRAME_US       = 1000,
  parameter int TIMEOUT_US     = 5000
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NUM_NODES-1:0] node_done,
  output logic [NUM_NODES-1:0] node_nreset,
  output logic                 frame_tick,
  output logic [10:0]          frame_num,
  output logic [31:0]          cycle_count,
  output logic                 all_done,
  output logic                 timeout,
  output logic                 finished
);

  localparam logic [31:0] FRAME_CYCLES  = 32'(CLK_FREQ_MHZ * FRAME_US);
  localparam logic [31:0] FRAME_LAST    = FRAME_CYCLES - 32'd1;
  localparam logic [31:0] TIMEOUT_COUNT = 32'(CLK_FREQ_MHZ * TIMEOUT_US);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [31:0]          cycle_inc_s;
  logic                 timeout_hit_s;
  logic [NUM_NODES-1:0] node_nreset_q, node_nreset_d;
  logic [NUM_NODES-1:0] done_q, done_d;
  logic [31:0]          frame_cnt_q, frame_cnt_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [10:0]          frame_num_q, frame_num_d;
  logic                 all_done_q, all_done_d;
  logic                 timeout_q, timeout_d;
  logic                 finished_q, finished_d;

  // Next-state computation for the sequencer and all registered outputs.
  always_comb begin
    state_d       = state_q;
    cycle_d       = cycle_q;
    node_nreset_d = node_nreset_q;
    done_d        = done_q;
    frame_cnt_d   = frame_cnt_q;
    frame_tick_d  = 1'b0;
    frame_num_d   = frame_num_q;

    cycle_inc_s   = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
    timeout_hit_s = (cycle_inc_s >= TIMEOUT_COUNT);

    case (state_q)
      ST_RESET, ST_RUN: begin
        cycle_d = cycle_inc_s;
        for (int i = 0; i < NUM_NODES; i++) begin
          if (cycle_inc_s == 32'(RESET_CYCLES + i * STAGGER_CYCLES)) begin
            node_nreset_d[i] = 1'b1;
          end else begin
            node_nreset_d[i] = node_nreset_q[i];
          end
        end
        // A node still held in reset cannot complete.
        done_d = done_q | (node_done & node_nreset_q);

        if (state_q == ST_RESET) begin
          if (timeout_hit_s) begin
            state_d = ST_TIMEOUT;
          end else if (node_nreset_d[NUM_NODES-1]) begin
            state_d     = ST_RUN;
            frame_cnt_d = 32'd0;
          end else begin
            state_d = ST_RESET;
          end
        end else begin
          if (&done_q) begin
            state_d = ST_DONE;
          end else if (timeout_hit_s) begin
            state_d = ST_TIMEOUT;
          end else if (frame_cnt_q >= FRAME_LAST) begin
            frame_cnt_d  = 32'd0;
            frame_tick_d = 1'b1;
            frame_num_d  = frame_num_q + 11'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
          end
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    all_done_d = (state_d == ST_DONE);
    timeout_d  = (state_d == ST_TIMEOUT);
    finished_d = all_done_d | timeout_d;
  end

  // State and output registers; nreset clears everything asynchronously.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= ST_RESET;
      cycle_q       <= 32'd0;
      node_nreset_q <= '0;
      done_q        <= '0;
      frame_cnt_q   <= 32'd0;
      frame_tick_q  <= 1'b0;
      frame_num_q   <= 11'd0;
      all_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
      finished_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      node_nreset_q <= node_nreset_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_tick_q  <= frame_tick_d;
      frame_num_q   <= frame_num_d;
      all_done_q    <= all_done_d;
      timeout_q     <= timeout_d;
      finished_q    <= finished_d;
    end
  end

`ifdef USB_TB_SEQ_SIM_EN
  // Console report and end of simulation on entry to a terminal state.
  always_ff @(posedge clk) begin
    if (nreset && (state_q != ST_TIMEOUT) && (state_d == ST_TIMEOUT)) begin
      $display("***ERROR: simulation timed out at cycle %0d", cycle_d);
      $finish;
    end else if (nreset && (state_q != ST_DONE) && (state_d == ST_DONE)) begin
      $display("usb_tb_sequencer: all nodes done at cycle %0d, frame %0d", cycle_d, frame_num_d);
      $finish;
    end
  end
`endif

  assign node_nreset = node_nreset_q;
  assign frame_tick  = frame_tick_q;
  assign frame_num   = frame_num_q;
  assign cycle_count = cycle_q;
  assign all_done    = all_done_q;
  assign timeout     = timeout_q;
  assign finished    = finished_q;

endmodule

// File: tb/tb_usb_tb_sequencer.sv
// Directed bench for usb_tb_sequencer: defaults, staggered release with short frames, short timeout.
module tb_usb_tb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset_a, nreset_b, nreset_c;
  logic [1:0]  node_done_a, node_done_c;
  logic [3:0]  node_done_b;
  logic [1:0]  node_nreset_a, node_nreset_c;
  logic [3:0]  node_nreset_b;
  logic        frame_tick_a, frame_tick_b, frame_tick_c;
  logic [10:0] frame_num_a, frame_num_b, frame_num_c;
  logic [31:0] cycle_count_a, cycle_count_b, cycle_count_c;
  logic        all_done_a, all_done_b, all_done_c;
  logic        timeout_a, timeout_b, timeout_c;
  logic        finished_a, finished_b, finished_c;

  int errors = 0;
  int checks = 0;

  usb_tb_sequencer u_a (
    .clk(clk), .nreset(nreset_a), .node_done(node_done_a), .node_nreset(node_nreset_a),
    .frame_tick(frame_tick_a), .frame_num(frame_num_a), .cycle_count(cycle_count_a),
    .all_done(all_done_a), .timeout(timeout_a), .finished(finished_a)
  );

  usb_tb_sequencer #(
    .NUM_NODES(4), .CLK_FREQ_MHZ(1), .RESET_CYCLES(5), .STAGGER_CYCLES(3),
    .FRAME_US(4), .TIMEOUT_US(20000)
  ) u_b (
    .clk(clk), .nreset(nreset_b), .node_done(node_done_b), .node_nreset(node_nreset_b),
    .frame_tick(frame_tick_b), .frame_num(frame_num_b), .cycle_count(cycle_count_b),
    .all_done(all_done_b), .timeout(timeout_b), .finished(finished_b)
  );

  usb_tb_sequencer #(.TIMEOUT_US(2)) u_c (
    .clk(clk), .nreset(nreset_c), .node_done(node_done_c), .node_nreset(node_nreset_c),
    .frame_tick(frame_tick_c), .frame_num(frame_num_c), .cycle_count(cycle_count_c),
    .all_done(all_done_c), .timeout(timeout_c), .finished(finished_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  exp_rel;
    logic [10:0] exp_num;
    logic        exp_tick;

    nreset_a = 1'b0; nreset_b = 1'b0; nreset_c = 1'b0;
    node_done_a = 2'b00; node_done_b = 4'b0000; node_done_c = 2'b00;
    #2;
    check("a_rst_nrst",   32'(node_nreset_a), 32'd0);
    check("a_rst_cycle",  cycle_count_a,      32'd0);
    check("a_rst_fin",    32'(finished_a),    32'd0);
    check("a_rst_fnum",   32'(frame_num_a),   32'd0);
    tick(); tick();

    // Defaults: release at edge 10, ignored early done, completion tracking.
    nreset_a = 1'b1;
    repeat (8) tick();
    node_done_a = 2'b10;
    tick();
    check("a_e9_nrst",  32'(node_nreset_a), 32'd0);
    check("a_e9_cycle", cycle_count_a,      32'd9);
    node_done_a = 2'b00;
    tick();
    check("a_e10_nrst",  32'(node_nreset_a), 32'd3);
    check("a_e10_cycle", cycle_count_a,      32'd10);
    tick();
    node_done_a = 2'b01;
    tick();
    node_done_a = 2'b00;
    tick();
    check("a_e13_ignored_done", 32'(all_done_a), 32'd0);
    tick();
    node_done_a = 2'b10;
    tick();
    node_done_a = 2'b00;
    check("a_e15_alldone", 32'(all_done_a), 32'd0);
    tick();
    check("a_e16_alldone", 32'(all_done_a), 32'd1);
    check("a_e16_fin",     32'(finished_a), 32'd1);
    check("a_e16_tmo",     32'(timeout_a),  32'd0);
    check("a_e16_cycle",   cycle_count_a,   32'd16);
    repeat (3) tick();
    check("a_frozen_cycle", cycle_count_a,      32'd16);
    check("a_hold_nrst",    32'(node_nreset_a), 32'd3);
    check("a_done_tick",    32'(frame_tick_a),  32'd0);

    // Mid-run asynchronous reset, then full restart and first frame tick.
    nreset_a = 1'b0;
    tick();
    nreset_a = 1'b1;
    repeat (12) tick();
    #3 nreset_a = 1'b0;
    #1;
    check("a_async_nrst",  32'(node_nreset_a), 32'd0);
    check("a_async_cycle", cycle_count_a,      32'd0);
    check("a_async_fin",   32'(finished_a),    32'd0);
    tick();
    nreset_a = 1'b1;
    repeat (10) tick();
    check("a_re_nrst",  32'(node_nreset_a), 32'd3);
    check("a_re_cycle", cycle_count_a,      32'd10);
    repeat (11999) tick();
    check("a_e12009_tick", 32'(frame_tick_a), 32'd0);
    check("a_e12009_fnum", 32'(frame_num_a),  32'd0);
    tick();
    check("a_e12010_tick", 32'(frame_tick_a), 32'd1);
    check("a_e12010_fnum", 32'(frame_num_a),  32'd1);
    tick();
    check("a_e12011_tick", 32'(frame_tick_a), 32'd0);
    nreset_a = 1'b0;

    // Staggered release and 4-cycle frames through frame number wrap.
    nreset_b = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_rel = (e >= 14) ? 4'b1111 : (e >= 11) ? 4'b0111 : (e >= 8) ? 4'b0011 :
                (e >= 5) ? 4'b0001 : 4'b0000;
      check("b_release", 32'(node_nreset_b), 32'(exp_rel));
    end
    for (int e = 15; e <= 8206; e++) begin
      tick();
      exp_tick = (((e - 14) % 4) == 0);
      exp_num  = 11'(((e - 14) / 4) % 2048);
      check("b_ftick", 32'(frame_tick_b), 32'(exp_tick));
      check("b_fnum",  32'(frame_num_b),  32'(exp_num));
    end
    check("b_cycle", cycle_count_b, 32'd8206);
    nreset_b = 1'b0;

    // Timeout at 24 cycles, then completion colliding with the timeout edge.
    nreset_c = 1'b1;
    repeat (23) tick();
    check("c_e23_tmo", 32'(timeout_c),  32'd0);
    check("c_e23_fin", 32'(finished_c), 32'd0);
    tick();
    check("c_e24_tmo",   32'(timeout_c),    32'd1);
    check("c_e24_fin",   32'(finished_c),   32'd1);
    check("c_e24_done",  32'(all_done_c),   32'd0);
    check("c_e24_tick",  32'(frame_tick_c), 32'd0);
    check("c_e24_cycle", cycle_count_c,     32'd24);
    repeat (2) tick();
    check("c_frozen_cycle", cycle_count_c,  32'd24);
    check("c_hold_tmo",     32'(timeout_c), 32'd1);
    nreset_c = 1'b0;
    tick();
    nreset_c = 1'b1;
    repeat (22) tick();
    node_done_c = 2'b11;
    tick();
    node_done_c = 2'b00;
    check("c2_e23_done", 32'(all_done_c), 32'd0);
    check("c2_e23_tmo",  32'(timeout_c),  32'd0);
    tick();
    check("c2_e24_done",  32'(all_done_c), 32'd1);
    check("c2_e24_tmo",   32'(timeout_c),  32'd0);
    check("c2_e24_fin",   32'(finished_c), 32'd1);
    check("c2_e24_cycle", cycle_count_c,   32'd24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tb_sequencer.md
# usb_tb_sequencer

Parametrised simulation sequencer for usbModel test benches. It sits at the top level beside N usbModel nodes and replaces hand-written reset generation and timeout monitoring. It provides:
- staggered per-node reset release
- a free-running cycle count
- 1 ms full-speed frame ticks with an 11-bit frame number
- per-node completion tracking and a timeout monitor

## Interface
Parameters:
- NUM_NODES, 2: number of usbModel nodes controlled (1..16)
- CLK_FREQ_MHZ, 12: clock frequency in MHz
- RESET_CYCLES, 10: cycles after nreset deassertion until node 0 leaves reset (>=1)
- STAGGER_CYCLES, 0: extra release delay per node index
- FRAME_US, 1000: frame period in µs; FRAME_CYCLES = CLK_FREQ_MHZ*FRAME_US
- TIMEOUT_US, 5000: timeout in µs; TIMEOUT_COUNT = CLK_FREQ_MHZ*TIMEOUT_US

Ports:
- clk  input  1  system clock, all state on rising edge
- nreset  input  1  asynchronous, active-low reset
- node_done  input  NUM_NODES  per-node completion indication
- node_nreset  output  NUM_NODES  per-node active-low reset to usbModel instances
- frame_tick  output  1  one-cycle pulse at each frame boundary
- frame_num  output  11  current frame number
- cycle_count  output  32  cycles since reset deassertion
- all_done  output  1  every node has signalled completion
- timeout  output  1  timeout reached before completion
- finished  output  1  all_done | timeout

## Operation
- Reset (nreset low, asynchronous): all outputs 0; node_nreset all 0; state RESET; done latches cleared.
- States: RESET -> RUN -> DONE or TIMEOUT. DONE and TIMEOUT are terminal until nreset.
- cycle_count increments by 1 on every edge in RESET and RUN. It freezes in DONE/TIMEOUT and saturates at 0xFFFFFFFF.
- node_nreset[i] goes high on the edge at which cycle_count becomes RESET_CYCLES + i*STAGGER_CYCLES. It then stays high until nreset.
- RESET -> RUN on the edge releasing the last node (index NUM_NODES-1).
- Frame counter runs only in RUN. It counts 0..FRAME_CYCLES-1 and restarts at RUN entry.
- frame_tick is high for the one cycle following the edge where the frame counter wraps.
- frame_num increments on that same edge and wraps 2047 -> 0.
- Done latch i is set when node_done[i]=1 and node_nreset[i]=1. node_done from a node still in reset is ignored. Latches are sticky.
- RUN -> DONE on the edge after all latches are set; all_done goes to 1.
- TIMEOUT: when cycle_count reaches TIMEOUT_COUNT in RESET or RUN, the next state is TIMEOUT and timeout goes to 1.
- Simultaneous completion and timeout on the same edge: DONE wins; timeout stays 0.
- In DONE/TIMEOUT: frame_tick is forced to 0, frame_num holds, node_nreset holds.
- nreset asserted mid-run returns all outputs to reset values immediately. Sequencing restarts from cycle 0 on deassertion.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Node 0 release latency is RESET_CYCLES edges after the first edge with nreset high.
- With defaults, node_nreset[1:0] go 0b00 -> 0b11 at edge 10.
- node_done -> all_done latency: 2 edges (latch, then state update).
- First frame_tick: FRAME_CYCLES edges after RUN entry, e.g. 12000 with defaults.
- finished asserts on the same edge as all_done or timeout.

## Configuration
- USB_TB_SEQ_SIM_EN defined:
  - on entry to TIMEOUT the block prints "***ERROR: simulation timed out" with cycle_count, then calls $finish;
  - on entry to DONE it prints a pass message with cycle_count and frame_num, then calls $finish.
- USB_TB_SEQ_SIM_EN undefined: no system tasks. The block is synthesizable and reports only through all_done, timeout and finished.

## Test plan
- Defaults, release nreset at t0: node_nreset=0b00 until edge 10, then 0b11; state RUN; cycle_count=10.
- NUM_NODES=4, RESET_CYCLES=5, STAGGER_CYCLES=3: node_nreset becomes 0b0001, 0b0011, 0b0111, 0b1111 at edges 5, 8, 11, 14.
- CLK_FREQ_MHZ=1, FRAME_US=4: frame_tick pulses every 4 cycles in RUN; frame_num wraps 2047 -> 0 on the 2048th tick.
- Pulse node_done[1] while node_nreset[1]=0: ignored. Pulse node_done[0] then node_done[1] after release: all_done=1 two edges after the second pulse, cycle_count frozen.
- TIMEOUT_US=2, CLK_FREQ_MHZ=12, no node_done: timeout=1 on the edge cycle_count reaches 24, finished=1, frame_tick stays 0. Completion on the same edge as timeout gives all_done=1, timeout=0.
- Assert nreset mid-RUN: all outputs 0 immediately, without waiting for a clock edge. On release the sequence repeats from edge 1.
